ppu_regif_dma: RTL and testbench
================================

Name: ppu_regif_dma

Overview:
- Next-generation CPU-side PPU register interface: $2000-$2007 (mirrored every 8 bytes across $2000-$3FFF), plus an integrated $4014 OAM DMA engine that halts the CPU.
- Keeps Loopy V/T/fineX/w state, the $2007 read buffer with palette bypass, the vblank flag with read-race suppression, and NMI generation.
- Sits between the CPU bus decoder and the PPU render core, OAM RAM and VRAM arbiter.

Parameters:
- OAM_AW, 8, OAM address width; OAM depth is 2^OAM_AW.
- VRAM_AW, 14, width of the VRAM address driven out; Loopy V wraps modulo 2^VRAM_AW.
- DMA_LEN, 256, bytes per DMA transfer; power of two, 2..256.
- DMA_PORT, 16'h4014, CPU address that triggers DMA.

Ports:
- i_cpu_clk  in  1  CPU clock; all logic on posedge.
- i_cpu_rstn  in  1  async active-low reset.
- i_bus_addr  in  16  CPU address.
- i_bus_wn  in  1  0 = write, 1 = read.
- i_bus_wdata  in  8  CPU write data.
- o_ppu_rdata  out  8  read data; 0 when not addressed.
- o_cpu_halt  out  1  stalls the CPU during DMA.
- o_dma_addr  out  16  DMA source address.
- o_dma_rd  out  1  DMA read strobe.
- i_dma_rdata  in  8  DMA source data; valid the cycle after o_dma_rd.
- o_oam_addr  out  OAM_AW  OAM address.
- o_oam_we  out  1  OAM write enable.
- o_oam_wdata  out  8  OAM write data.
- i_oam_rdata  in  8  OAM read data (combinational).
- o_vram_addr  out  VRAM_AW  current Loopy V.
- o_vram_we  out  1  $2007 write strobe.
- o_vram_wdata  out  8  $2007 write data.
- i_vram_rdata  in  8  VRAM data at o_vram_addr (combinational).
- o_ppuctrl  out  8  PPUCTRL.
- o_ppumask  out  8  PPUMASK.
- o_loopyT  out  15  Loopy T.
- o_fineX  out  3  fine X scroll.
- i_spr_ovfl  in  1  sprite overflow flag.
- i_spr_0hit  in  1  sprite 0 hit flag.
- i_vblank  in  1  vblank level from the renderer.
- o_nmi_n  out  1  active-low NMI.

Behaviour:
- Reset values:
  - Registers, T, V, fineX, w, read buffer, open-bus latch and vbl flag: 0.
  - o_nmi_n = 1, o_cpu_halt = 0, o_dma_rd = 0, o_oam_we = 0, o_vram_we = 0.
  - FSM in IDLE.
- Register hit: i_bus_addr[15:13] == 3'b001; register index = addr[2:0].
- Side-effect gating: while o_cpu_halt = 1, no register side effect occurs. This covers $2002/$2007 reads and all bus writes.
- Open-bus latch: any register write loads wdata[4:0] into the latch.
- $2000 write: ctrl <= d; T[11:10] <= d[1:0].
- $2001 write: mask <= d.
- $2003 write: oamaddr <= d.
- $2004 write: OAM write at oamaddr, then oamaddr + 1 (wraps).
- $2004 read: returns i_oam_rdata; no increment.
- $2005 write:
  - w = 0: T[4:0] <= d[7:3], fineX <= d[2:0].
  - w = 1: T[9:5] <= d[7:3], T[14:12] <= d[2:0].
  - w toggles.
- $2006 write:
  - w = 0: T[14:8] <= {1'b0, d[5:0]}.
  - w = 1: T[7:0] <= d and V <= new T, in the same cycle.
  - w toggles.
- $2002 read:
  - Returns {vbl, i_spr_0hit, i_spr_ovfl, openbus[4:0]}.
  - Next cycle: vbl <= 0, w <= 0.
- $2007 access:
  - After the access, V <= V + (ctrl[2] ? 32 : 1), modulo 2^VRAM_AW.
  - Write: o_vram_we = 1 that cycle.
  - Read, palette (V[13:8] == 6'h3F): returns i_vram_rdata directly.
  - Read, otherwise: returns the read buffer.
  - Every read: buffer <= i_vram_rdata.
- vbl flag:
  - Set on the cycle after a rising edge of i_vblank; cleared when i_vblank falls.
  - A $2002 read in the rising-edge cycle returns bit7 = 0 and suppresses the set for this frame.
- NMI:
  - o_nmi_n = ~(vbl & ctrl[7]), registered.
  - Writing ctrl[7] 0->1 while vbl = 1 asserts NMI on the next cycle.
- DMA FSM, states IDLE / ALIGN / RD / WR:
  - IDLE -> ALIGN on a CPU write to DMA_PORT: page <= d, cnt <= 0.
  - ALIGN -> RD after 1 cycle.
  - RD: o_dma_rd = 1, o_dma_addr = {page, 8'(cnt)}; -> WR.
  - WR: o_oam_we = 1, o_oam_wdata = i_dma_rdata, o_oam_addr = oamaddr; oamaddr + 1; cnt + 1.
  - WR -> IDLE when cnt == DMA_LEN-1, else -> RD.
  - o_cpu_halt = 1 in ALIGN/RD/WR; total 1 + 2*DMA_LEN cycles (513 by default).
  - DMA_PORT writes during DMA are ignored.
  - OAM muxes select the DMA source in WR, register path otherwise.
  - oamaddr wraps, so a nonzero start rotates placement.
- Async reset mid-DMA: immediately IDLE, halt deasserted; no further OAM writes.

Test Plan:
- Write $2006 = 0x21 then 0x08; read $2007 twice with ctrl[2] = 0 -> 1st returns the stale buffer (0), 2nd returns mem[0x2108]; V = 0x210A afterwards.
- Set V = 0x3F00 and read $2007 -> returns palette byte immediately; V = 0x3F01; buffer holds the underlying data.
- Write $2005 = 0x7D then 0x5E -> T[4:0] = 0x0F, fineX = 5, T[9:5] = 0x0B, T[14:12] = 6; a $2002 read then resets w so the next $2005 write is X.
- ctrl[7] = 1 and i_vblank rises -> o_nmi_n = 0 next cycle. $2002 read -> bit7 = 1, then o_nmi_n = 1. Repeat with the $2002 read on the rising edge -> bit7 = 0 and no NMI that frame.
- oamaddr = 0x04; write $4014 = 0x02 -> halt for exactly 513 cycles; OAM[(0x04+i) & 0xFF] = mem[0x0200+i]; oamaddr back to 0x04.
- Assert i_cpu_rstn low at DMA cycle 100 -> halt = 0 and oam_we = 0 immediately; after release FSM is IDLE and OAM is unchanged beyond entries already written.

Source files
------------

// File: rtl/ppu_regif_dma.sv
// CPU-side PPU register interface ($2000-$2007, mirrored through $3FFF) with
// Loopy scroll state, $2007 read buffer, vblank/NMI logic and a $4014 OAM DMA
// engine that halts the CPU while it copies one page into OAM.
//
// DMA state | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer, CPU runs, register side effects enabled
// ST_ALIGN  | one dead cycle after the $4014 write
// ST_RD     | source read strobe for byte cnt
// ST_WR     | source byte lands, written to OAM at oamaddr
module ppu_regif_dma #(
    parameter int          OAM_AW   = 8,
    parameter int          VRAM_AW  = 14,
    parameter int          DMA_LEN  = 256,
    parameter logic [15:0] DMA_PORT = 16'h4014
) (
    input  logic               i_cpu_clk,
    input  logic               i_cpu_rstn,
    input  logic [15:0]        i_bus_addr,
    input  logic               i_bus_wn,
    input  logic [7:0]         i_bus_wdata,
    output logic [7:0]         o_ppu_rdata,
    output logic               o_cpu_halt,
    output logic [15:0]        o_dma_addr,
    output logic               o_dma_rd,
    input  logic [7:0]         i_dma_rdata,
    output logic [OAM_AW-1:0]  o_oam_addr,
    output logic               o_oam_we,
    output logic [7:0]         o_oam_wdata,
    input  logic [7:0]         i_oam_rdata,
    output logic [VRAM_AW-1:0] o_vram_addr,
    output logic               o_vram_we,
    output logic [7:0]         o_vram_wdata,
    input  logic [7:0]         i_vram_rdata,
    output logic [7:0]         o_ppuctrl,
    output logic [7:0]         o_ppumask,
    output logic [14:0]        o_loopyT,
    output logic [2:0]         o_fineX,
    input  logic               i_spr_ovfl,
    input  logic               i_spr_0hit,
    input  logic               i_vblank,
    output logic               o_nmi_n
);

    localparam int CW = (DMA_LEN > 2) ? $clog2(DMA_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DMA_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_RD, ST_WR} dma_state_t;

    dma_state_t          state;
    logic [7:0]          page;
    logic [CW-1:0]       cnt;

    logic [7:0]          ctrl;
    logic [7:0]          mask;
    logic [OAM_AW-1:0]   oamaddr;
    logic [14:0]         t;
    logic [VRAM_AW-1:0]  v;
    logic [2:0]          fine_x;
    logic                w;
    logic [7:0]          rbuf;
    logic [4:0]          openbus;
    logic                vblank_q;
    logic                vbl;

    logic                reg_hit;
    logic [2:0]          idx;
    logic                wr_en;
    logic                rd_en;
    logic                rd_status;
    logic                acc_data;
    logic                palette;
    logic                dma_go;
    logic [14:0]         t_lo_wr;
    logic [VRAM_AW-1:0]  v_step;

    // Bus decode; every register side effect is blocked while the CPU is halted.
    assign reg_hit   = (i_bus_addr[15:13] == 3'b001);
    assign idx       = i_bus_addr[2:0];
    assign wr_en     = reg_hit & ~i_bus_wn & ~o_cpu_halt;
    assign rd_en     = reg_hit &  i_bus_wn & ~o_cpu_halt;
    assign rd_status = rd_en & (idx == 3'd2);
    assign acc_data  = (wr_en | rd_en) & (idx == 3'd7);
    assign palette   = ((16'(v) >> 8) & 16'h003F) == 16'h003F;
    assign dma_go    = ~i_bus_wn & (i_bus_addr == DMA_PORT) & (state == ST_IDLE);
    assign t_lo_wr   = {t[14:8], i_bus_wdata};
    assign v_step    = ctrl[2] ? VRAM_AW'(32) : VRAM_AW'(1);

    // Control, mask, Loopy T/V/fineX/w, read buffer and open-bus latch.
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            ctrl    <= '0;
            mask    <= '0;
            t       <= '0;
            v       <= '0;
            fine_x  <= '0;
            w       <= 1'b0;
            rbuf    <= '0;
            openbus <= '0;
        end else begin
            if (wr_en) begin
                openbus <= i_bus_wdata[4:0];
                case (idx)
                    3'd0: begin
                        ctrl     <= i_bus_wdata;
                        t[11:10] <= i_bus_wdata[1:0];
                    end
                    3'd1: mask <= i_bus_wdata;
                    3'd5: begin
                        if (!w) begin
                            t[4:0] <= i_bus_wdata[7:3];
                            fine_x <= i_bus_wdata[2:0];
                        end else begin
                            t[9:5]   <= i_bus_wdata[7:3];
                            t[14:12] <= i_bus_wdata[2:0];
                        end
                        w <= ~w;
                    end
                    3'd6: begin
                        if (!w) begin
                            t[14:8] <= {1'b0, i_bus_wdata[5:0]};
                        end else begin
                            t <= t_lo_wr;
                            v <= VRAM_AW'(t_lo_wr);
                        end
                        w <= ~w;
                    end
                    default: ;
                endcase
            end
            if (rd_status) w <= 1'b0;
            if (acc_data) v <= v + v_step;
            if (rd_en && idx == 3'd7) rbuf <= i_vram_rdata;
        end
    end

    // OAM address: CPU $2003/$2004 path, or post-increment per DMA byte.
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            oamaddr <= '0;
        end else if (state == ST_WR) begin
            oamaddr <= oamaddr + 1'b1;
        end else if (wr_en && idx == 3'd3) begin
            oamaddr <= OAM_AW'(i_bus_wdata);
        end else if (wr_en && idx == 3'd4) begin
            oamaddr <= oamaddr + 1'b1;
        end
    end

    // Vblank flag with $2002 read-race suppression, and registered NMI.
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            vblank_q <= 1'b0;
            vbl      <= 1'b0;
            o_nmi_n  <= 1'b1;
        end else begin
            vblank_q <= i_vblank;
            if (!i_vblank) begin
                vbl <= 1'b0;
            end else if (!vblank_q && !rd_status) begin
                vbl <= 1'b1;
            end else if (rd_status) begin
                vbl <= 1'b0;
            end
            o_nmi_n <= ~(vbl & ctrl[7]);
        end
    end

    // DMA sequencer: ALIGN, then DMA_LEN read/write pairs, CPU halted throughout.
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            state      <= ST_IDLE;
            page       <= '0;
            cnt        <= '0;
            o_cpu_halt <= 1'b0;
            o_dma_rd   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dma_go) begin
                        state      <= ST_ALIGN;
                        page       <= i_bus_wdata;
                        cnt        <= '0;
                        o_cpu_halt <= 1'b1;
                    end
                end
                ST_ALIGN: begin
                    state    <= ST_RD;
                    o_dma_rd <= 1'b1;
                end
                ST_RD: begin
                    state    <= ST_WR;
                    o_dma_rd <= 1'b0;
                end
                ST_WR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state      <= ST_IDLE;
                        o_cpu_halt <= 1'b0;
                    end else begin
                        state    <= ST_RD;
                        o_dma_rd <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    o_cpu_halt <= 1'b0;
                    o_dma_rd   <= 1'b0;
                end
            endcase
        end
    end

    // CPU read data mux; zero whenever no PPU register is being read.
    always_comb begin
        o_ppu_rdata = 8'h00;
        if (reg_hit && i_bus_wn) begin
            case (idx)
                3'd2:    o_ppu_rdata = {vbl, i_spr_0hit, i_spr_ovfl, openbus};
                3'd4:    o_ppu_rdata = i_oam_rdata;
                3'd7:    o_ppu_rdata = palette ? i_vram_rdata : rbuf;
                default: o_ppu_rdata = 8'h00;
            endcase
        end
    end

    assign o_dma_addr   = {page, 8'(cnt)};
    assign o_oam_addr   = oamaddr;
    assign o_oam_we     = (state == ST_WR) | (wr_en & (idx == 3'd4));
    assign o_oam_wdata  = (state == ST_WR) ? i_dma_rdata : i_bus_wdata;
    assign o_vram_addr  = v;
    assign o_vram_we    = wr_en & (idx == 3'd7);
    assign o_vram_wdata = i_bus_wdata;
    assign o_ppuctrl    = ctrl;
    assign o_ppumask    = mask;
    assign o_loopyT     = t;
    assign o_fineX      = fine_x;

endmodule

// File: tb/tb_ppu_regif_dma.sv
// Directed bench for ppu_regif_dma: register path, Loopy state, $2007 buffer,
// vblank/NMI race, OAM DMA timing/placement and reset during DMA.
module tb_ppu_regif_dma;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        wn = 1'b1;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        halt;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_rdata = 8'h00;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata;
    logic [13:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [7:0]  ppuctrl;
    logic [7:0]  ppumask;
    logic [14:0] loopy_t;
    logic [2:0]  fine_x;
    logic        spr_ovfl = 1'b0;
    logic        spr_0hit = 1'b0;
    logic        vblank = 1'b0;
    logic        nmi_n;

    logic [7:0]  oam [256];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ppu_regif_dma dut (
        .i_cpu_clk(clk), .i_cpu_rstn(rstn),
        .i_bus_addr(addr), .i_bus_wn(wn), .i_bus_wdata(wdata),
        .o_ppu_rdata(rdata), .o_cpu_halt(halt),
        .o_dma_addr(dma_addr), .o_dma_rd(dma_rd), .i_dma_rdata(dma_rdata),
        .o_oam_addr(oam_addr), .o_oam_we(oam_we), .o_oam_wdata(oam_wdata),
        .i_oam_rdata(oam_rdata),
        .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_vram_wdata(vram_wdata),
        .i_vram_rdata(vram_rdata),
        .o_ppuctrl(ppuctrl), .o_ppumask(ppumask), .o_loopyT(loopy_t), .o_fineX(fine_x),
        .i_spr_ovfl(spr_ovfl), .i_spr_0hit(spr_0hit), .i_vblank(vblank), .o_nmi_n(nmi_n)
    );

    function automatic logic [7:0] vpat(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b11};
    endfunction

    function automatic logic [7:0] spat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign vram_rdata = vpat(vram_addr);
    assign oam_rdata  = oam[oam_addr];

    always @(posedge clk) begin
        if (dma_rd) dma_rdata <= spat(dma_addr);
        if (oam_we) oam[oam_addr] <= oam_wdata;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wn = 1'b0; wdata = d;
        @(posedge clk); #1;
        addr = 16'h0000; wn = 1'b1;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; wn = 1'b1;
        #1 d = rdata;
        @(posedge clk); #1;
        addr = 16'h0000;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int n;
        int nerr;

        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        cycles(3);
        @(negedge clk) rstn = 1'b1;
        cycles(1);

        // reset state
        check("rst_rdata", rdata, 8'h00);
        check("rst_nmi", nmi_n, 1'b1);
        check("rst_halt", halt, 1'b0);
        check("rst_dma_rd", dma_rd, 1'b0);
        check("rst_oam_we", oam_we, 1'b0);
        check("rst_vram_we", vram_we, 1'b0);
        check("rst_v", vram_addr, 14'h0000);
        check("rst_ctrl", ppuctrl, 8'h00);
        check("rst_t", loopy_t, 15'h0000);
        check("rst_finex", fine_x, 3'd0);
        bus_rd(16'h2002, d);
        check("rst_status", d, 8'h00);

        // mirrored mask write
        bus_wr(16'h3FF9, 8'h1E);
        check("mask_mirror", ppumask, 8'h1E);
        bus_wr(16'h2000, 8'h00);

        // $2006 address load and buffered $2007 reads
        bus_wr(16'h2006, 8'h21);
        check("t_hi", loopy_t, 15'h2100);
        bus_wr(16'h2006, 8'h08);
        check("t_full", loopy_t, 15'h2108);
        check("v_load", vram_addr, 14'h2108);
        bus_rd(16'h2007, d);
        check("rd2007_stale", d, 8'h00);
        bus_rd(16'h2007, d);
        check("rd2007_buf", d, vpat(14'h2108));
        check("v_after_rd", vram_addr, 14'h210A);

        // $2007 write strobe
        @(negedge clk);
        addr = 16'h2007; wn = 1'b0; wdata = 8'hC3;
        #1;
        check("vram_we", vram_we, 1'b1);
        check("vram_wdata", vram_wdata, 8'hC3);
        check("vram_wr_addr", vram_addr, 14'h210A);
        @(posedge clk); #1;
        addr = 16'h0000; wn = 1'b1;
        #1;
        check("vram_we_off", vram_we, 1'b0);
        check("v_after_wr", vram_addr, 14'h210B);

        // palette read bypasses the buffer but still refills it
        bus_wr(16'h2006, 8'h3F);
        bus_wr(16'h2006, 8'h00);
        bus_rd(16'h2007, d);
        check("pal_direct", d, vpat(14'h3F00));
        check("pal_v", vram_addr, 14'h3F01);
        bus_wr(16'h2006, 8'h20);
        bus_wr(16'h2006, 8'h00);
        bus_rd(16'h2007, d);
        check("pal_buf", d, vpat(14'h3F00));

        // increment by 32 wraps modulo 2^14; $2000 loads T[11:10]
        bus_wr(16'h2000, 8'h04);
        bus_wr(16'h2006, 8'h3F);
        bus_wr(16'h2006, 8'hF0);
        bus_rd(16'h2007, d);
        check("v_inc32_wrap", vram_addr, 14'h0010);
        bus_wr(16'h2000, 8'h02);
        check("ctrl_val", ppuctrl, 8'h02);
        check("t_nt_bits", loopy_t, 15'h3BF0);
        bus_wr(16'h2000, 8'h00);

        // $2005 scroll writes and w reset by $2002
        bus_rd(16'h2002, d);
        bus_wr(16'h2006, 8'h00);
        bus_wr(16'h2006, 8'h00);
        bus_wr(16'h2005, 8'h7D);
        check("scroll_x_t", loopy_t, 15'h000F);
        check("scroll_finex", fine_x, 3'd5);
        bus_wr(16'h2005, 8'h5E);
        check("scroll_y_t", loopy_t, 15'h616F);
        bus_wr(16'h2005, 8'h10);
        bus_rd(16'h2002, d);
        check("status_openbus", d, 8'h10);
        bus_wr(16'h2005, 8'h48);
        check("w_reset_t", loopy_t, 15'h6169);
        check("w_reset_finex", fine_x, 3'd0);

        // sprite flags in status
        spr_0hit = 1'b1; spr_ovfl = 1'b1;
        bus_rd(16'h3FFA, d);
        check("status_flags", d, 8'h68);
        spr_0hit = 1'b0; spr_ovfl = 1'b0;

        // $2003/$2004
        bus_wr(16'h2003, 8'h10);
        bus_wr(16'h2004, 8'h77);
        check("oam_reg_wr", oam[8'h10], 8'h77);
        bus_wr(16'h2003, 8'h10);
        bus_rd(16'h2004, d);
        check("oam_rd1", d, 8'h77);
        bus_rd(16'h2004, d);
        check("oam_rd_noinc", d, 8'h77);

        // NMI on vblank, cleared by $2002
        bus_wr(16'h2000, 8'h80);
        @(negedge clk) vblank = 1'b1;
        cycles(2);
        check("nmi_on_vbl", nmi_n, 1'b0);
        bus_rd(16'h2002, d);
        check("status_vbl", d, 8'h80);
        cycles(2);
        check("nmi_cleared", nmi_n, 1'b1);
        @(negedge clk) vblank = 1'b0;
        cycles(3);

        // $2002 read on the rising-edge cycle suppresses the frame
        @(negedge clk);
        vblank = 1'b1; addr = 16'h2002; wn = 1'b1;
        #1 d = rdata;
        @(posedge clk); #1;
        addr = 16'h0000;
        check("race_bit7", d, 8'h00);
        cycles(3);
        check("race_no_nmi", nmi_n, 1'b1);
        bus_rd(16'h2002, d);
        check("race_vbl_clr", d, 8'h00);

        // enabling NMI while vbl already set
        @(negedge clk) vblank = 1'b0;
        cycles(2);
        bus_wr(16'h2000, 8'h00);
        @(negedge clk) vblank = 1'b1;
        cycles(3);
        check("nmi_masked", nmi_n, 1'b1);
        bus_wr(16'h2000, 8'h80);
        cycles(2);
        check("nmi_late_en", nmi_n, 1'b0);
        @(negedge clk) vblank = 1'b0;
        cycles(3);
        check("nmi_vbl_fall", nmi_n, 1'b1);
        bus_wr(16'h2000, 8'h00);

        // full DMA from page 2 at oamaddr 4; writes during halt must be ignored
        bus_wr(16'h2003, 8'h04);
        bus_wr(16'h4014, 8'h02);
        n = 0;
        while (halt === 1'b1 && n < 1000) begin
            n++;
            if (n == 10) begin
                addr = 16'h2001; wn = 1'b0; wdata = 8'hFF;
            end else if (n == 11) begin
                addr = 16'h4014; wn = 1'b0; wdata = 8'h03;
            end else begin
                addr = 16'h0000; wn = 1'b1;
            end
            @(posedge clk); #1;
        end
        addr = 16'h0000; wn = 1'b1;
        check("dma_halt_cycles", 16'(n), 16'd513);
        check("dma_mask_kept", ppumask, 8'h1E);
        nerr = 0;
        for (int i = 0; i < 256; i++)
            if (oam[(i + 4) & 255] !== spat(16'h0200 + 16'(i))) nerr++;
        check("dma_oam_data", 16'(nerr), 16'd0);
        cycles(2);
        check("dma_no_restart", halt, 1'b0);
        bus_rd(16'h2004, d);
        check("dma_oamaddr_back", d, spat(16'h0200));

        // reset during DMA while a WR cycle is in progress (48 bytes done)
        bus_wr(16'h2003, 8'h00);
        bus_wr(16'h4014, 8'h03);
        for (int k = 1; k < 99; k++) begin
            @(posedge clk); #1;
        end
        check("mid_halt", halt, 1'b1);
        check("mid_oam_we", oam_we, 1'b1);
        rstn = 1'b0;
        #1;
        check("rst_mid_halt", halt, 1'b0);
        check("rst_mid_oam_we", oam_we, 1'b0);
        check("rst_mid_dma_rd", dma_rd, 1'b0);
        cycles(3);
        @(negedge clk) rstn = 1'b1;
        cycles(4);
        check("post_rst_halt", halt, 1'b0);
        check("post_rst_mask", ppumask, 8'h00);
        nerr = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < 48) begin
                if (oam[i] !== spat(16'h0300 + 16'(i))) nerr++;
            end else begin
                if (oam[i] !== spat(16'h0200 + 16'((i - 4) & 255))) nerr++;
            end
        end
        check("rst_mid_oam", 16'(nerr), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
